// File: rtl/parallel_assembler_pkg.sv
// Shared types and helpers for the byte-to-word assembler.
// Holds the fill/hold state encoding and lane geometry helpers.
package parallel_assembler_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } asm_state_e;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int lane_lo(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/asm_out_stage.sv
// Valid/ready holding register for completed frames.
// A new frame may be loaded whenever the current one is absent or being taken.
module asm_out_stage
    import parallel_assembler_pkg::*;
#(
    parameter int WIDTH = 120
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             bus_ready,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_valid,
    output logic             out_free
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    assign out_free  = !r_valid | bus_ready;
    assign bus_out   = r_data;
    assign bus_valid = r_valid;

    // Frame register: load takes precedence, otherwise a completed handshake empties it.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            r_data  <= {WIDTH{1'b0}};
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= load_data;
            r_valid <= 1'b1;
        end else if (r_valid && bus_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

endmodule

// File: rtl/parallel_assembler.sv
// Collects DW-bit lanes into an NBYTES-lane frame and hands complete frames
// to a valid/ready output stage; one extra frame can be parked while the consumer stalls.
module parallel_assembler
    import parallel_assembler_pkg::*;
#(
    parameter  int NBYTES = 15,
    parameter  int DW     = 8,
    localparam int IDXW   = idx_width(NBYTES)
) (
    input  logic                 mclk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic [DW-1:0]        data_in,
    input  logic [IDXW-1:0]      use_dw,
    input  logic                 auto_inc,
    input  logic                 last,
    input  logic                 clr,
    output logic                 wr_ready,
    output logic [NBYTES*DW-1:0] bus_out,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic [IDXW:0]        byte_cnt,
    output logic                 overrun
);

    localparam int             FW        = NBYTES * DW;
    localparam logic [IDXW:0]  NB_EXT    = (IDXW+1)'(NBYTES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    asm_state_e      r_state;
    logic [FW-1:0]   r_fill;
    logic [IDXW-1:0] r_ptr;
    logic [IDXW:0]   r_cnt;
    logic            r_overrun;

    logic [IDXW-1:0] w_lane;
    logic            w_addr_bad;
    logic            w_accept;
    logic            w_commit;
    logic            w_out_free;
    logic            w_load;
    logic [FW-1:0]   w_fill_merged;
    logic [FW-1:0]   w_load_data;
    logic [IDXW:0]   w_cnt_next;

    assign wr_ready = (r_state == FILL);
    assign byte_cnt = r_cnt;
    assign overrun  = r_overrun;

    // Write decode: lane selection, range check, commit detection and output load.
    always_comb begin
        w_lane      = auto_inc ? r_ptr : use_dw;
        w_addr_bad  = !auto_inc && ({1'b0, use_dw} >= NB_EXT);
        w_accept    = (r_state == FILL) && wr && !clr && !w_addr_bad;
        w_commit    = w_accept && (last || (auto_inc && (r_ptr == LAST_IDX)));
        w_cnt_next  = (r_cnt == NB_EXT) ? r_cnt : r_cnt + (IDXW+1)'(1);
        if (r_state == HOLD) begin
            w_load      = !clr && w_out_free;
            w_load_data = r_fill;
        end else begin
            w_load      = w_commit && w_out_free;
            w_load_data = w_fill_merged;
        end
    end

    // Fill buffer with the current write folded in, so a committing lane reaches the output directly.
    always_comb begin
        w_fill_merged = r_fill;
        for (int k = 0; k < NBYTES; k++) begin
            if (w_lane == IDXW'(k)) begin
                w_fill_merged[lane_lo(k, DW) +: DW] = data_in;
            end else begin
                w_fill_merged[lane_lo(k, DW) +: DW] = r_fill[lane_lo(k, DW) +: DW];
            end
        end
    end

    // Fill/hold sequencing, pointer, count and sticky error flag.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            r_state   <= FILL;
            r_fill    <= {FW{1'b0}};
            r_ptr     <= {IDXW{1'b0}};
            r_cnt     <= {(IDXW+1){1'b0}};
            r_overrun <= 1'b0;
        end else if (clr) begin
            r_state   <= FILL;
            r_fill    <= {FW{1'b0}};
            r_ptr     <= {IDXW{1'b0}};
            r_cnt     <= {(IDXW+1){1'b0}};
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (wr && w_addr_bad) begin
                        r_overrun <= 1'b1;
                    end else if (w_commit && w_out_free) begin
                        r_fill <= {FW{1'b0}};
                        r_ptr  <= {IDXW{1'b0}};
                        r_cnt  <= {(IDXW+1){1'b0}};
                    end else if (w_commit) begin
                        // Park the finished frame here until the output stage frees up.
                        r_fill  <= w_fill_merged;
                        r_cnt   <= w_cnt_next;
                        r_ptr   <= {IDXW{1'b0}};
                        r_state <= HOLD;
                    end else if (w_accept) begin
                        r_fill <= w_fill_merged;
                        r_cnt  <= w_cnt_next;
                        r_ptr  <= auto_inc ? r_ptr + IDXW'(1) : r_ptr;
                    end else begin
                        r_fill <= r_fill;
                    end
                end
                HOLD: begin
                    if (wr) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_overrun <= r_overrun;
                    end
                    if (w_out_free) begin
                        r_fill  <= {FW{1'b0}};
                        r_ptr   <= {IDXW{1'b0}};
                        r_cnt   <= {(IDXW+1){1'b0}};
                        r_state <= FILL;
                    end else begin
                        r_state <= HOLD;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    asm_out_stage #(
        .WIDTH(FW)
    ) u_out (
        .mclk      (mclk),
        .reset     (reset),
        .load      (w_load),
        .load_data (w_load_data),
        .bus_ready (bus_ready),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .out_free  (w_out_free)
    );

endmodule
